z_sdram_wr_arbiter: RTL
=======================

Name: z_sdram_wr_arbiter

Overview:
- Round-robin arbiter sharing the single SDRAM write port (24-bit Bank+Row+Column address, 16-bit data, req/done handshake) among NUM_REQ draw requesters, e.g. the draw sequencer and a background-fill engine.
- Grants one single-word write transaction at a time and holds the grant until the SDRAM controller returns done.
- Sits between the draw engines and the SDRAM controller write interface.
- Includes a watchdog so a hung controller cannot lock out drawing.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
TIMEOUT, 1023, max cycles in ISSUE waiting for iSDRAM_Wr_Done before abort.
TW, 10, watchdog counter width; must hold TIMEOUT.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
en  in  1  1 = new grants allowed; 0 = finish current transaction, then idle.
iReq  in  NUM_REQ  per-requester write request; level, held until oDone.
iAddr  in  24*NUM_REQ  per-requester address; requester k at bits [24k+23:24k].
iData  in  16*NUM_REQ  per-requester data; requester k at bits [16k+15:16k].
oGrant  out  NUM_REQ  one-hot current owner; all zero in IDLE.
oDone  out  NUM_REQ  one-cycle pulse to the owner when its write completes.
oSDRAM_Wr_Addr  out  24  address to the SDRAM controller.
oSDRAM_Wr_Data  out  16  data to the SDRAM controller.
oSDRAM_Wr_Req  out  1  write request to the controller; level.
iSDRAM_Wr_Done  in  1  controller write-done pulse.
oBusy  out  1  1 in any state other than IDLE.
oErr  out  1  sticky watchdog-abort flag.
oErrId  out  2  index of the requester owning the grant at the last abort.
iErrClr  in  1  clears oErr and oErrId.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=NUM_REQ-1, wdog=0. All outputs are registered and reset to 0 (oGrant, oDone, oSDRAM_Wr_Addr/Data/Req, oBusy, oErr, oErrId).
- Reset asserted mid-transaction drops oSDRAM_Wr_Req immediately. No oDone is issued.
- FSM: IDLE -> SETUP -> ISSUE -> RELEASE -> IDLE.
- IDLE, when en=1 and any iReq bit is set:
  - Winner = first set bit searching upward from rr_ptr+1 (mod NUM_REQ).
  - Set oGrant one-hot and latch that requester's iAddr/iData into oSDRAM_Wr_Addr/Data.
  - Go to SETUP.
- SETUP (1 cycle):
  - Address and data are stable; oSDRAM_Wr_Req stays 0. This is the settle cycle the controller requires.
  - If the owner's iReq dropped, go to RELEASE with no oDone. Otherwise go to ISSUE.
- ISSUE:
  - oSDRAM_Wr_Req=1; wdog increments each cycle.
  - On iSDRAM_Wr_Done=1: next cycle oSDRAM_Wr_Req=0, oDone[owner]=1 for one cycle, go to RELEASE.
  - Owner dropping iReq in ISSUE is ignored, because the SDRAM command is in flight; oDone is still pulsed.
  - If wdog reaches TIMEOUT with no done:
    - oSDRAM_Wr_Req=0, oErr=1, oErrId=owner index.
    - No oDone is issued. Go to RELEASE.
- RELEASE (1 cycle):
  - oGrant=0, rr_ptr=owner index, wdog=0, go to IDLE.
  - Guarantees at least one req-low cycle between transactions.
- Latency: iReq rise in IDLE -> oGrant at +1 -> oSDRAM_Wr_Req at +2. Done at cycle d -> oDone at d+1. Minimum back-to-back period is 4 cycles plus controller latency.
- iSDRAM_Wr_Done outside ISSUE is ignored.
- en=0 only blocks the IDLE->SETUP transition. A transaction already in flight completes normally.
- iErrClr=1 clears oErr and oErrId. If iErrClr and a new abort occur in the same cycle, the abort wins (oErr=1).
- Round-robin fairness: with all requesters continuously asserting, each is granted exactly once per NUM_REQ transactions.
- oBusy = (state != IDLE).

Test Plan:
1. Single requester: iReq=01, iAddr0=24'h000123, iData0=16'hF800; controller returns done 5 cycles after req. Required: oGrant=01 at +1; oSDRAM_Wr_Req high from +2 through the done cycle; oSDRAM_Wr_Addr=000123, oSDRAM_Wr_Data=F800; oDone=01 for exactly 1 cycle.
2. Contention: iReq=11 held for 4 transactions from reset. Required: grant order 0,1,0,1; a req-low gap of at least 1 cycle between each.
3. Watchdog: TIMEOUT=8, iReq=10, iSDRAM_Wr_Done never asserted. Required: oSDRAM_Wr_Req drops after 8 ISSUE cycles; oErr=1; oErrId=1; no oDone; then iErrClr=1 clears oErr.
4. Request withdrawal: iReq0 drops during SETUP. Required: oSDRAM_Wr_Req never rises and no oDone. Separately, iReq0 drops during ISSUE: oDone still pulses on done.
5. en gating and reset: en=0 with iReq=01 gives no grant; then en=1 gives a grant at +1. Asserting rst in ISSUE clears all outputs asynchronously; after release, state is IDLE and the first grant goes to requester 0.

Source files
------------

// File: rtl/z_sdram_wr_arbiter.sv
// Round-robin arbiter sharing the single SDRAM write port among NUM_REQ draw requesters.
// One single-word write in flight at a time; a watchdog aborts a hung controller.
module z_sdram_wr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TW      = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_REQ-1:0]      iReq,
  input  logic [24*NUM_REQ-1:0]   iAddr,
  input  logic [16*NUM_REQ-1:0]   iData,
  output logic [NUM_REQ-1:0]      oGrant,
  output logic [NUM_REQ-1:0]      oDone,
  output logic [23:0]             oSDRAM_Wr_Addr,
  output logic [15:0]             oSDRAM_Wr_Data,
  output logic                    oSDRAM_Wr_Req,
  input  logic                    iSDRAM_Wr_Done,
  output logic                    oBusy,
  output logic                    oErr,
  output logic [1:0]              oErrId,
  input  logic                    iErrClr
);

  typedef enum logic [1:0] {StIdle, StSetup, StIssue, StRelease} stateT;

  stateT              state, stateNext;
  logic [1:0]         rrPtr, rrPtrNext;
  logic [1:0]         ownerIdx, ownerNext;
  logic [TW-1:0]      wdog, wdogNext, wdogInc;
  logic [NUM_REQ-1:0] grantNext, doneNext;
  logic [23:0]        addrNext;
  logic [15:0]        dataNext;
  logic               reqNext, busyNext, errNext;
  logic [1:0]         errIdNext;

  // Inputs padded to four slots so a 2-bit index is always in range.
  logic [3:0]  reqPad;
  logic [23:0] addrArr [4];
  logic [15:0] dataArr [4];

  for (genvar g = 0; g < 4; g++) begin : gPad
    if (g < NUM_REQ) begin : gUsed
      assign reqPad[g]  = iReq[g];
      assign addrArr[g] = iAddr[24*g +: 24];
      assign dataArr[g] = iData[16*g +: 16];
    end else begin : gUnused
      assign reqPad[g]  = 1'b0;
      assign addrArr[g] = '0;
      assign dataArr[g] = '0;
    end
  end

  logic       winFound;
  logic [1:0] winIdx, cand;
  logic [3:0] winOneHot;

  // First requester strictly after the previous owner, wrapping modulo NUM_REQ.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    cand     = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand = 2'((int'(rrPtr) + k) % int'(NUM_REQ));
      if (!winFound && reqPad[cand]) begin
        winFound = 1'b1;
        winIdx   = cand;
      end
    end
    winOneHot = 4'b0001 << winIdx;
  end

  always_comb begin
    stateNext = state;
    rrPtrNext = rrPtr;
    ownerNext = ownerIdx;
    wdogNext  = wdog;
    wdogInc   = wdog + TW'(1);
    grantNext = oGrant;
    doneNext  = '0;
    addrNext  = oSDRAM_Wr_Addr;
    dataNext  = oSDRAM_Wr_Data;
    reqNext   = oSDRAM_Wr_Req;
    errNext   = oErr;
    errIdNext = oErrId;

    if (iErrClr) begin
      errNext   = 1'b0;
      errIdNext = '0;
    end

    unique case (state)
      StIdle: begin
        if (en && winFound) begin
          stateNext = StSetup;
          ownerNext = winIdx;
          grantNext = winOneHot[NUM_REQ-1:0];
          addrNext  = addrArr[winIdx];
          dataNext  = dataArr[winIdx];
        end
      end
      StSetup: begin
        if (!reqPad[ownerIdx]) begin
          stateNext = StRelease;
        end else begin
          stateNext = StIssue;
          reqNext   = 1'b1;
        end
      end
      StIssue: begin
        // Owner withdrawal is ignored here: the command is already in flight.
        wdogNext = wdogInc;
        if (iSDRAM_Wr_Done) begin
          stateNext = StRelease;
          reqNext   = 1'b0;
          doneNext  = oGrant;
        end else if (wdogInc == TW'(TIMEOUT)) begin
          stateNext = StRelease;
          reqNext   = 1'b0;
          errNext   = 1'b1;
          errIdNext = ownerIdx;
        end
      end
      StRelease: begin
        stateNext = StIdle;
        grantNext = '0;
        rrPtrNext = ownerIdx;
        wdogNext  = '0;
      end
      default: stateNext = StIdle;
    endcase

    busyNext = (stateNext != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= StIdle;
      rrPtr          <= 2'(NUM_REQ - 1);
      ownerIdx       <= '0;
      wdog           <= '0;
      oGrant         <= '0;
      oDone          <= '0;
      oSDRAM_Wr_Addr <= '0;
      oSDRAM_Wr_Data <= '0;
      oSDRAM_Wr_Req  <= 1'b0;
      oBusy          <= 1'b0;
      oErr           <= 1'b0;
      oErrId         <= '0;
    end else begin
      state          <= stateNext;
      rrPtr          <= rrPtrNext;
      ownerIdx       <= ownerNext;
      wdog           <= wdogNext;
      oGrant         <= grantNext;
      oDone          <= doneNext;
      oSDRAM_Wr_Addr <= addrNext;
      oSDRAM_Wr_Data <= dataNext;
      oSDRAM_Wr_Req  <= reqNext;
      oBusy          <= busyNext;
      oErr           <= errNext;
      oErrId         <= errIdNext;
    end
  end

endmodule
